// File: rtl/dm_arb_if.sv
// dm_arb_if: the request/response bundle for one requester of dm_arbiter.
//
// Signals (requester-side view):
//   req   - access request, level; held with its fields until gnt is seen
//   we    - 1 = store, 0 = load
//   addr  - 6-bit byte address
//   wdata - 32-bit store data
//   dtype - 3-bit DMType (000 word, 001 half, 010 half unsigned,
//           011 byte, 100 byte unsigned)
//   gnt   - one-cycle grant pulse, high during the memory access cycle
//   done  - one-cycle completion pulse, the cycle after gnt
//   rdata - load data, valid with done on a load; held between done pulses
//   err   - alignment/range error, valid with done
//
// Modports: master = requester, slave = arbiter.
`default_nettype none

interface dm_arb_if;
  logic        req;
  logic        we;
  logic [5:0]  addr;
  logic [31:0] wdata;
  logic [2:0]  dtype;
  logic        gnt;
  logic        done;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, addr, wdata, dtype,
    input  gnt, done, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata, dtype,
    output gnt, done, rdata, err
  );
endinterface

`default_nettype wire

// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port round-robin arbiter and sequencer in front of the
// data memory. Requester 0 (CPU LSU) and requester 1 (DMA/debug) share one
// memory port. A winning command is latched in IDLE, drives the memory for
// exactly one ACCESS cycle, and completes with done/rdata/err the cycle after.
//
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous, active-high reset
//   p0, p1   - dm_arb_if.slave requester bundles (req/we/addr/wdata/dtype in,
//              gnt/done/rdata/err out)
//   DMWr     - memory write enable
//   dm_addr  - memory byte address
//   dm_din   - memory write data
//   DMType   - memory access type
//   dm_dout  - combinational read data from the memory
//   busy     - high while in ACCESS
//
// Configuration macro: DM_ARB_ALIGN_CHECK_EN
//   defined   - commands with addr[5]=1, misaligned word/halfword addresses or
//               an undefined type (101-111) are suppressed (no write, rdata 0)
//               and complete with err=1.
//   undefined - err is always 0 and every command goes to the memory as is.
`default_nettype none

module dm_arbiter (
  input  logic        clk,
  input  logic        rst,
  dm_arb_if.slave     p0,
  dm_arb_if.slave     p1,
  output logic        DMWr,
  output logic [5:0]  dm_addr,
  output logic [31:0] dm_din,
  output logic [2:0]  DMType,
  input  logic [31:0] dm_dout,
  output logic        busy
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic        ptr_q, ptr_d;       // last granted port
  logic        win_q, win_d;       // port owning the current command
  logic        latch_cmd;

  logic        we_q;
  logic [5:0]  addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  type_q;

  logic        done0_q, done1_q;
  logic        err0_q, err1_q;
  logic [31:0] rdata0_q, rdata1_q;

  logic        in_access;
  logic        cmd_err;
  logic [31:0] rd_val;

`ifdef DM_ARB_ALIGN_CHECK_EN
  function automatic logic align_err(input logic [5:0] a, input logic [2:0] t);
    logic e;
    e = a[5];
    if (t == 3'b000 && a[1:0] != 2'b00) e = 1'b1;
    if ((t == 3'b001 || t == 3'b010) && a[0]) e = 1'b1;
    if (t > 3'b100) e = 1'b1;
    return e;
  endfunction

  assign cmd_err = align_err(addr_q, type_q);
`else
  assign cmd_err = 1'b0;
`endif

  assign in_access = (state_q == S_ACCESS);

  // Suppressed commands and stores return zero data.
  assign rd_val = (cmd_err || we_q) ? 32'h0 : dm_dout;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    latch_cmd = 1'b0;
    DMWr      = 1'b0;
    dm_addr   = 6'h0;
    dm_din    = 32'h0;
    DMType    = 3'b000;
    busy      = 1'b0;
    p0.gnt    = 1'b0;
    p1.gnt    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (p0.req || p1.req) begin
          // On a tie the port not granted last wins; otherwise the sole requester.
          win_d     = (p0.req && p1.req) ? ~ptr_q : p1.req;
          ptr_d     = win_d;
          latch_cmd = 1'b1;
          state_d   = S_ACCESS;
        end
      end
      S_ACCESS: begin
        busy    = 1'b1;
        p0.gnt  = ~win_q;
        p1.gnt  = win_q;
        DMWr    = we_q & ~cmd_err;
        dm_addr = addr_q;
        dm_din  = wdata_q;
        DMType  = type_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and response registers; async reset also aborts a pending ACCESS,
  // which drops DMWr immediately and cancels its done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= 1'b1;
      win_q    <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      rdata0_q <= 32'h0;
      rdata1_q <= 32'h0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      done0_q <= in_access & ~win_q;
      done1_q <= in_access & win_q;
      err0_q  <= in_access & ~win_q & cmd_err;
      err1_q  <= in_access & win_q & cmd_err;
      if (in_access && !win_q) rdata0_q <= rd_val;
      if (in_access && win_q)  rdata1_q <= rd_val;
    end
  end

  // Command latch: data only, qualified by state so it needs no reset.
  always_ff @(posedge clk) begin
    if (latch_cmd) begin
      we_q    <= win_d ? p1.we    : p0.we;
      addr_q  <= win_d ? p1.addr  : p0.addr;
      wdata_q <= win_d ? p1.wdata : p0.wdata;
      type_q  <= win_d ? p1.dtype : p0.dtype;
    end
  end

  assign p0.done  = done0_q;
  assign p1.done  = done1_q;
  assign p0.err   = err0_q;
  assign p1.err   = err1_q;
  assign p0.rdata = rdata0_q;
  assign p1.rdata = rdata1_q;

endmodule

`default_nettype wire

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: self-checking bench for dm_arbiter. Contains a behavioural
// data memory on the memory side, a transaction-level reference model
// (byte array + expected rdata per port) and randomized single-port traffic,
// plus directed tie, extension, alignment and mid-access reset sequences.
// Follows DM_ARB_ALIGN_CHECK_EN for expected error behaviour.
`timescale 1ns/1ps

module tb_dm_arbiter;

  logic        clk;
  logic        rst;
  logic        DMWr;
  logic [5:0]  dm_addr;
  logic [31:0] dm_din;
  logic [2:0]  DMType;
  logic [31:0] dm_dout;
  logic        busy;

  dm_arb_if p0_if ();
  dm_arb_if p1_if ();

  dm_arbiter dut (
    .clk     (clk),
    .rst     (rst),
    .p0      (p0_if),
    .p1      (p1_if),
    .DMWr    (DMWr),
    .dm_addr (dm_addr),
    .dm_din  (dm_din),
    .DMType  (DMType),
    .dm_dout (dm_dout),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory attached to the arbiter: little-endian, low 5 address bits.
  logic [7:0] mem [32] = '{default: 8'h00};

  always_comb begin
    logic [4:0]  b;
    logic [31:0] w;
    b = dm_addr[4:0];
    w = {mem[5'(b + 3)], mem[5'(b + 2)], mem[5'(b + 1)], mem[b]};
    case (DMType)
      3'd0:    dm_dout = w;
      3'd1:    dm_dout = {{16{w[15]}}, w[15:0]};
      3'd2:    dm_dout = {16'h0, w[15:0]};
      3'd3:    dm_dout = {{24{w[7]}}, w[7:0]};
      3'd4:    dm_dout = {24'h0, w[7:0]};
      default: dm_dout = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (DMWr) begin
      case (DMType)
        3'd0: begin
          mem[dm_addr[4:0]]         <= dm_din[7:0];
          mem[5'(dm_addr[4:0] + 1)] <= dm_din[15:8];
          mem[5'(dm_addr[4:0] + 2)] <= dm_din[23:16];
          mem[5'(dm_addr[4:0] + 3)] <= dm_din[31:24];
        end
        3'd1, 3'd2: begin
          mem[dm_addr[4:0]]         <= dm_din[7:0];
          mem[5'(dm_addr[4:0] + 1)] <= dm_din[15:8];
        end
        3'd3, 3'd4: mem[dm_addr[4:0]] <= dm_din[7:0];
        default: ;
      endcase
    end
  end

  // Reference model state.
  logic [7:0]  ref_mem [32] = '{default: 8'h00};
  logic [31:0] exp_rd [2] = '{32'h0, 32'h0};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int acc_size(input logic [2:0] ty);
    if (ty == 3'd0) return 4;
    if (ty == 3'd1 || ty == 3'd2) return 2;
    return 1;
  endfunction

  function automatic logic model_err(input logic [5:0] a, input logic [2:0] ty);
`ifdef DM_ARB_ALIGN_CHECK_EN
    if (a[5]) return 1'b1;
    if (ty > 3'd4) return 1'b1;
    if (ty == 3'd0 && (a % 4) != 0) return 1'b1;
    if ((ty == 3'd1 || ty == 3'd2) && (a % 2) != 0) return 1'b1;
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_load(input logic [5:0] a, input logic [2:0] ty);
    logic [31:0] v;
    int n;
    v = 32'h0;
    n = acc_size(ty);
    for (int i = 0; i < n; i++)
      v = v | (32'(ref_mem[(int'(a) + i) % 32]) << (8 * i));
    if (ty == 3'd1 && v >= 32'h8000) v = v - 32'h10000;
    if (ty == 3'd3 && v >= 32'h80) v = v - 32'h100;
    return v;
  endfunction

  task automatic model_store(input logic [5:0] a, input logic [2:0] ty, input logic [31:0] wd);
    int n;
    n = acc_size(ty);
    for (int i = 0; i < n; i++)
      ref_mem[(int'(a) + i) % 32] = 8'(wd >> (8 * i));
  endtask

  task automatic drive(input int port, input logic r, input logic we, input logic [5:0] a,
                       input logic [31:0] wd, input logic [2:0] ty);
    if (port == 0) begin
      p0_if.req = r; p0_if.we = we; p0_if.addr = a; p0_if.wdata = wd; p0_if.dtype = ty;
    end else begin
      p1_if.req = r; p1_if.we = we; p1_if.addr = a; p1_if.wdata = wd; p1_if.dtype = ty;
    end
  endtask

  function automatic logic gnt_of(input int port);
    return (port == 0) ? p0_if.gnt : p1_if.gnt;
  endfunction
  function automatic logic done_of(input int port);
    return (port == 0) ? p0_if.done : p1_if.done;
  endfunction
  function automatic logic err_of(input int port);
    return (port == 0) ? p0_if.err : p1_if.err;
  endfunction
  function automatic logic [31:0] rdata_of(input int port);
    return (port == 0) ? p0_if.rdata : p1_if.rdata;
  endfunction

  // One isolated access on one port, starting from IDLE.
  task automatic xact(input int port, input logic we, input logic [5:0] a,
                      input logic [31:0] wd, input logic [2:0] ty);
    logic        e;
    logic [31:0] er;
    e = model_err(a, ty);
    @(posedge clk); #1;
    drive(port, 1'b1, we, a, wd, ty);
    @(negedge clk);
    chk("gnt_early", 32'(gnt_of(port)), 32'd0);
    @(negedge clk);
    chk("gnt", 32'(gnt_of(port)), 32'd1);
    chk("gnt_other", 32'(gnt_of(1 - port)), 32'd0);
    chk("busy_acc", 32'(busy), 32'd1);
    chk("dmwr", 32'(DMWr), 32'(we & ~e));
    chk("dm_addr", 32'(dm_addr), 32'(a));
    chk("dm_din", dm_din, wd);
    chk("dmtype", 32'(DMType), 32'(ty));
    drive(port, 1'b0, we, a, wd, ty);
    if (e) er = 32'h0;
    else if (we) begin
      model_store(a, ty, wd);
      er = 32'h0;
    end else er = model_load(a, ty);
    exp_rd[port] = er;
    @(negedge clk);
    chk("done", 32'(done_of(port)), 32'd1);
    chk("err", 32'(err_of(port)), 32'(e));
    chk("rdata", rdata_of(port), er);
    chk("done_other", 32'(done_of(1 - port)), 32'd0);
    chk("rdata_other", rdata_of(1 - port), exp_rd[1 - port]);
    chk("idle_dmwr", 32'(DMWr), 32'd0);
    chk("idle_addr", 32'(dm_addr), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  // Both ports hold load requests; grants must alternate starting with p0.
  // ncyc is a multiple of 4 so the loop ends on a p1 grant cycle.
  task automatic tie_test(input int ncyc);
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 6'd4, 32'h1111_1111, 3'd0);
    drive(1, 1'b1, 1'b0, 6'd9, 32'h2222_2222, 3'd3);
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      chk("tie_gnt_done",
          32'({p0_if.gnt, p1_if.gnt, p0_if.done, p1_if.done}),
          32'({k % 4 == 1, k % 4 == 3, k % 4 == 2, (k % 4 == 0) && (k > 0)}));
    end
    drive(0, 1'b0, 1'b0, 6'd4, 32'h1111_1111, 3'd0);
    drive(1, 1'b0, 1'b0, 6'd9, 32'h2222_2222, 3'd3);
    exp_rd[0] = model_load(6'd4, 3'd0);
    exp_rd[1] = model_load(6'd9, 3'd3);
    @(negedge clk);
    chk("tie_last_done1", 32'(p1_if.done), 32'd1);
    chk("tie_rdata0", p0_if.rdata, exp_rd[0]);
    chk("tie_rdata1", p1_if.rdata, exp_rd[1]);
    @(negedge clk);
    chk("tie_quiet", 32'({p0_if.gnt, p1_if.gnt, p0_if.done, p1_if.done}), 32'd0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_gnt_done_err"},
        32'({p0_if.gnt, p1_if.gnt, p0_if.done, p1_if.done, p0_if.err, p1_if.err}), 32'd0);
    chk({tag, "_rdata0"}, p0_if.rdata, 32'h0);
    chk({tag, "_rdata1"}, p1_if.rdata, 32'h0);
    chk({tag, "_mem_side"}, 32'({DMWr, dm_addr, DMType, busy}), 32'd0);
    chk({tag, "_dm_din"}, dm_din, 32'h0);
  endtask

  initial begin
    logic [2:0] ty;
    int         port;
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 6'd0, 32'h0, 3'd0);
    drive(1, 1'b0, 1'b0, 6'd0, 32'h0, 3'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_state("reset");
    rst = 1'b0;

    // Tie right after reset: p0 first, strict alternation.
    tie_test(8);

    // Word store then load on p0.
    xact(0, 1'b1, 6'd4, 32'hDEADBEEF, 3'd0);
    xact(0, 1'b0, 6'd4, 32'h0, 3'd0);
    chk("word_rt", p0_if.rdata, 32'hDEADBEEF);

    // Byte store on p1, then signed and unsigned byte loads.
    xact(1, 1'b1, 6'd9, 32'h0000_0080, 3'd3);
    xact(1, 1'b0, 6'd9, 32'h0, 3'd3);
    chk("lb_sext", p1_if.rdata, 32'hFFFFFF80);
    xact(1, 1'b0, 6'd9, 32'h0, 3'd4);
    chk("lbu_zext", p1_if.rdata, 32'h00000080);

    // Misaligned word store, then read back the neighbouring word.
    xact(0, 1'b1, 6'd6, 32'hCAFEF00D, 3'd0);
    xact(0, 1'b0, 6'd4, 32'h0, 3'd0);
`ifdef DM_ARB_ALIGN_CHECK_EN
    chk("align_unchanged", p0_if.rdata, 32'hDEADBEEF);
`else
    chk("align_written", p0_if.rdata, 32'hF00DBEEF);
`endif

    // Randomized single-port traffic.
    for (int i = 0; i < 40; i++) begin
`ifdef DM_ARB_ALIGN_CHECK_EN
      ty = 3'($urandom_range(0, 7));
`else
      ty = 3'($urandom_range(0, 4));
`endif
      port = int'($urandom_range(0, 1));
      xact(port, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), $urandom, ty);
    end

    // Reset in the middle of a store's ACCESS cycle.
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b1, 6'd16, 32'h12345678, 3'd0);
    @(negedge clk);
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_dmwr_drop", 32'({DMWr, busy, p0_if.gnt}), 32'd0);
    drive(0, 1'b0, 1'b1, 6'd16, 32'h12345678, 3'd0);
    @(negedge clk);
    chk_reset_state("abort");
    rst = 1'b0;
    exp_rd[0] = 32'h0;
    exp_rd[1] = 32'h0;
    @(negedge clk);
    chk("abort_no_done", 32'({p0_if.done, p1_if.done}), 32'd0);

    // Pointer is back at its reset value: p0 wins the next tie.
    tie_test(4);

    // The aborted store must not have reached memory.
    xact(1, 1'b0, 6'd16, 32'h0, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
